// File: rtl/audio_pkg.sv
// Shared types and constants for the audio tone generator.
// Half periods are 25 MHz clk cycles per half of the square wave.
`timescale 1ns/1ps
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic [4:0] PWM_LAST = 5'd30;

  // 25e6 / (2 * f), C4 .. D5, index 0 is the rest slot
  localparam logic [19:0] NOTE_HALF [0:15] = '{
    20'd0,
    20'd47778,
    20'd45097,
    20'd42566,
    20'd40177,
    20'd37922,
    20'd35793,
    20'd33784,
    20'd31888,
    20'd30098,
    20'd28409,
    20'd26815,
    20'd25310,
    20'd23889,
    20'd22548,
    20'd21283
  };

endpackage

// File: rtl/audio_tone_gen_note_rom.sv
// Note select to half period lookup.
// Scaled by DIV_SHIFT and floored at one cycle.
`timescale 1ns/1ps
module note_rom
  import audio_pkg::*;
#(
  parameter int unsigned DIV_SHIFT = 0
) (
  input  logic [3:0]  sel,
  output logic [19:0] half
);

  logic [19:0] shifted;

  always_comb begin
    shifted = NOTE_HALF[sel] >> DIV_SHIFT;
    half    = (shifted == '0) ? 20'd1 : shifted;
  end

endmodule

// File: rtl/audio_tone_gen.sv
// Note player: square tone, sustain then linear release,
// amplitude applied as 5-bit PWM on a registered output.
`timescale 1ns/1ps
module audio_tone_gen
  import audio_pkg::*;
#(
  parameter int unsigned NOTE_LEN  = 6_250_000,
  parameter int unsigned REL_STEP  = 250_000,
  parameter int unsigned DIV_SHIFT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       audioEn,
  input  logic [3:0] audioSel,
  input  logic [4:0] audioVol,
  output logic       pwm_out,
  output logic       playing,
  output logic [4:0] level
);

  localparam logic [31:0] DUR_LAST = 32'(NOTE_LEN - 1);
  localparam logic [31:0] REL_LAST = 32'(REL_STEP - 1);

  state_e      state;
  logic [3:0]  cur_sel;
  logic [31:0] dur_cnt;
  logic [31:0] rel_cnt;
  logic [19:0] half_cnt;
  logic [4:0]  pwm_cnt;
  logic        tone;
  logic [19:0] cmd_half;
  logic [19:0] cur_half;
  logic        start;
  logic        stop;

  // new note needs its period now, running note needs the latched one
  note_rom #(.DIV_SHIFT(DIV_SHIFT)) u_cmd_rom (
    .sel  (audioSel),
    .half (cmd_half)
  );

  note_rom #(.DIV_SHIFT(DIV_SHIFT)) u_cur_rom (
    .sel  (cur_sel),
    .half (cur_half)
  );

  assign start   = audioEn && (audioSel != '0) && (audioVol != '0);
  assign stop    = audioEn && !start;
  assign playing = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cur_sel  <= '0;
      level    <= '0;
      dur_cnt  <= '0;
      rel_cnt  <= '0;
      half_cnt <= '0;
      pwm_cnt  <= '0;
      tone     <= 1'b0;
      pwm_out  <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? 5'd0 : pwm_cnt + 5'd1;
      pwm_out <= tone & (pwm_cnt < level);
      if (start) begin
        state    <= PLAY;
        cur_sel  <= audioSel;
        level    <= audioVol;
        dur_cnt  <= '0;
        rel_cnt  <= '0;
        tone     <= 1'b0;
        half_cnt <= cmd_half - 20'd1;
      end else if (stop) begin
        state    <= IDLE;
        level    <= '0;
        dur_cnt  <= '0;
        rel_cnt  <= '0;
        tone     <= 1'b0;
        half_cnt <= '0;
      end else begin
        if (state != IDLE) begin
          if (half_cnt == '0) begin
            half_cnt <= cur_half - 20'd1;
            tone     <= ~tone;
          end else begin
            half_cnt <= half_cnt - 20'd1;
          end
        end
        // later tone writes override the toggle above
        unique case (state)
          IDLE: begin
            tone <= 1'b0;
          end
          PLAY: begin
            if (dur_cnt == DUR_LAST) begin
              state   <= RELEASE;
              rel_cnt <= '0;
            end else begin
              dur_cnt <= dur_cnt + 32'd1;
            end
          end
          RELEASE: begin
            if (rel_cnt == REL_LAST) begin
              rel_cnt <= '0;
              if (level == 5'd1) begin
                state <= IDLE;
                level <= '0;
                tone  <= 1'b0;
              end else begin
                level <= level - 5'd1;
              end
            end else begin
              rel_cnt <= rel_cnt + 32'd1;
            end
          end
          default: begin
            state <= IDLE;
            tone  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
